// File: rtl/wb_commit_ctrl.sv
// Register-file write-side controller: arbitrates ALU/LSU results onto the registered
// write port, tracks in-flight destinations in a busy scoreboard, and exposes bypass hits.
module wb_commit_ctrl #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int LSU_PRIO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            we3,
  output logic [AW-1:0]   wa3,
  output logic [XLEN-1:0] wd3,
  input  logic [AW-1:0]   q_ra1,
  input  logic [AW-1:0]   q_ra2,
  output logic            q_busy1,
  output logic            q_busy2,
  output logic            byp1_hit,
  output logic            byp2_hit
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] busy_q, busy_d;
  logic            clr_hit;
  logic            iss_fire;
  logic            gnt;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;

  // An issue to a register whose write lands on this edge is accepted: the clear and
  // the new set happen together, and the set wins below.
  assign clr_hit   = we3 && (wa3 == iss_rd);
  assign iss_ready = (iss_rd == '0) || !busy_q[iss_rd] || clr_hit;
  assign iss_fire  = iss_valid && iss_ready;

  // Single grant per cycle; the loser holds its request.
  always_comb begin
    if (LSU_PRIO != 0) begin
      lsu_ready = lsu_valid;
      alu_ready = alu_valid && !lsu_valid;
    end else begin
      alu_ready = alu_valid;
      lsu_ready = lsu_valid && !alu_valid;
    end
  end

  assign gnt      = alu_ready || lsu_ready;
  assign gnt_rd   = lsu_ready ? lsu_rd   : alu_rd;
  assign gnt_data = lsu_ready ? lsu_data : alu_data;

  // NOTE: combinational blocks assign a full default first so no path leaves a bit
  // unassigned, which would infer a latch; blocking '=' is correct here.
  always_comb begin
    busy_d = busy_q;
    if (we3) busy_d[wa3] = 1'b0;
    if (iss_fire && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it can and must be cleared on
  // reset; sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      we3    <= 1'b0;
      wa3    <= '0;
      wd3    <= '0;
    end else begin
      busy_q <= busy_d;
      we3    <= gnt && (gnt_rd != '0);
      if (gnt && (gnt_rd != '0)) begin
        wa3 <= gnt_rd;
        wd3 <= gnt_data;
      end
    end
  end

  assign q_busy1  = busy_q[q_ra1];
  assign q_busy2  = busy_q[q_ra2];
  assign byp1_hit = we3 && (wa3 == q_ra1) && (q_ra1 != '0);
  assign byp2_hit = we3 && (wa3 == q_ra2) && (q_ra2 != '0);

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Directed self-checking bench for wb_commit_ctrl (LSU_PRIO=1); inputs change and
// outputs are sampled 1ns after the rising edge.
module tb_wb_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, alu_valid, lsu_valid;
  logic [4:0]  iss_rd, alu_rd, lsu_rd, q_ra1, q_ra2;
  logic [31:0] alu_data, lsu_data;
  logic        iss_ready, alu_ready, lsu_ready;
  logic        we3, q_busy1, q_busy2, byp1_hit, byp2_hit;
  logic [4:0]  wa3;
  logic [31:0] wd3;

  int checks   = 0;
  int failures = 0;

  wb_commit_ctrl #(.XLEN(32), .AW(5), .LSU_PRIO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    iss_valid = 0; iss_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    q_ra1 = 0; q_ra2 = 0;
    repeat (2) tick();
    check("rst_we3", 32'(we3), 0);
    check("rst_wa3", 32'(wa3), 0);
    check("rst_wd3", wd3, 0);
    rst_n = 1'b1;
    tick();

    // Issue x5, ALU returns x5 two cycles later
    iss_valid = 1; iss_rd = 5; q_ra1 = 5; #1;
    check("t2_iss_ready", 32'(iss_ready), 1);
    tick();
    iss_valid = 0; #1;
    check("t2_busy_after_issue", 32'(q_busy1), 1);
    tick();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; #1;
    check("t2_alu_ready", 32'(alu_ready), 1);
    check("t2_busy_before_commit", 32'(q_busy1), 1);
    tick();
    alu_valid = 0; #1;
    check("t2_we3", 32'(we3), 1);
    check("t2_wa3", 32'(wa3), 5);
    check("t2_wd3", wd3, 32'hDEADBEEF);
    check("t2_byp1", 32'(byp1_hit), 1);
    check("t2_busy_in_commit", 32'(q_busy1), 1);
    tick();
    check("t2_we3_off", 32'(we3), 0);
    check("t2_busy_cleared", 32'(q_busy1), 0);
    check("t2_byp1_off", 32'(byp1_hit), 0);

    // Simultaneous ALU x3 / LSU x4, LSU wins
    alu_valid = 1; alu_rd = 3; alu_data = 32'h3333_3333;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h4444_4444; #1;
    check("t3_lsu_ready", 32'(lsu_ready), 1);
    check("t3_alu_ready", 32'(alu_ready), 0);
    tick();
    lsu_valid = 0; #1;
    check("t3_wa3_first", 32'(wa3), 4);
    check("t3_wd3_first", wd3, 32'h4444_4444);
    check("t3_alu_ready_next", 32'(alu_ready), 1);
    tick();
    alu_valid = 0; #1;
    check("t3_we3_second", 32'(we3), 1);
    check("t3_wa3_second", 32'(wa3), 3);
    check("t3_wd3_second", wd3, 32'h3333_3333);
    tick();
    check("t3_we3_off", 32'(we3), 0);

    // WAW on x7: blocked until commit cycle, then set wins over clear
    iss_valid = 1; iss_rd = 7; q_ra1 = 7; #1;
    check("t4_first_issue", 32'(iss_ready), 1);
    tick();
    check("t4_reissue_blocked", 32'(iss_ready), 0);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77; #1;
    check("t4_still_blocked", 32'(iss_ready), 0);
    tick();
    alu_valid = 0; #1;
    check("t4_commit_we3", 32'(we3), 1);
    check("t4_iss_ready_commit", 32'(iss_ready), 1);
    tick();
    iss_valid = 0; #1;
    check("t4_busy_set_wins", 32'(q_busy1), 1);
    check("t4_we3_off", 32'(we3), 0);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
    tick();
    alu_valid = 0;
    tick();
    check("t4_busy_cleared", 32'(q_busy1), 0);

    // Result to x0 is consumed without a write
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; q_ra1 = 0; #1;
    check("t5_alu_ready", 32'(alu_ready), 1);
    tick();
    alu_valid = 0; #1;
    check("t5_we3", 32'(we3), 0);
    check("t5_busy_x0", 32'(q_busy1), 0);
    iss_valid = 1; iss_rd = 0; #1;
    check("t5_iss_x0_ready", 32'(iss_ready), 1);
    tick();
    iss_valid = 0; #1;
    check("t5_busy_x0_after_issue", 32'(q_busy1), 0);

    // Issue x1..x31, then back-to-back ALU commits
    for (int i = 1; i < 32; i++) begin
      iss_valid = 1; iss_rd = 5'(i); #1;
      check("t6_issue", 32'(iss_ready), 1);
      tick();
    end
    iss_valid = 0; #1;
    for (int i = 1; i < 32; i++) begin
      q_ra2 = 5'(i); #1;
      check("t6_busy_set", 32'(q_busy2), 1);
    end
    for (int i = 1; i < 32; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'(i) * 32'h0101_0101;
      tick();
      check("t6_we3", 32'(we3), 1);
      check("t6_wa3", 32'(wa3), 32'(i));
      check("t6_wd3", wd3, 32'(i) * 32'h0101_0101);
    end
    alu_valid = 0;
    tick();
    check("t6_we3_off", 32'(we3), 0);
    for (int i = 0; i < 32; i++) begin
      q_ra2 = 5'(i); #1;
      check("t6_busy_clear", 32'(q_busy2), 0);
    end

    // Asynchronous reset while a write is on the port
    iss_valid = 1; iss_rd = 9; q_ra1 = 9;
    tick();
    iss_valid = 0;
    alu_valid = 1; alu_rd = 9; alu_data = 32'hCAFE_F00D;
    tick();
    alu_valid = 0; #1;
    check("t1_we3_pre", 32'(we3), 1);
    check("t1_busy_pre", 32'(q_busy1), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t1_we3", 32'(we3), 0);
    check("t1_wa3", 32'(wa3), 0);
    check("t1_wd3", wd3, 0);
    check("t1_busy", 32'(q_busy1), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
